multi_ball_box_top: RTL and testbench

- Parametrised VGA bouncing-ball demo top: `NUM_BALLS` square balls move inside a rectangular wall and bounce off it.
- Contains its own 640x480 sync generation, button handling and a registered pixel output.
- Adds pause/resume and runtime speed selection.
- Sits directly on the board pins: `clk` is the 25 MHz pixel clock.

---
 rtl/vga_pkg.sv | 84 ++++++++
 rtl/vga_timing.sv | 45 ++++
 rtl/multi_ball_box_top.sv | 178 +++++++++++++++++
 tb/tb_multi_ball_box_top.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, box defaults and the per-axis bounce step
// used by the multi-ball demo.
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int H_W     = 10;
  localparam int V_W     = 10;
  localparam int POS_W   = 10;
  localparam int SPEED_W = 3;

  localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_VIS_END  = H_W'(H_VISIBLE);
  localparam logic [H_W-1:0] HS_FIRST   = H_W'(H_VISIBLE + H_FRONT);
  localparam logic [H_W-1:0] HS_LAST    = H_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_VIS_END  = V_W'(V_VISIBLE);
  localparam logic [V_W-1:0] V_VIS_LAST = V_W'(V_VISIBLE - 1);
  localparam logic [V_W-1:0] VS_FIRST   = V_W'(V_VISIBLE + V_FRONT);
  localparam logic [V_W-1:0] VS_LAST    = V_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  localparam int DEF_BOX_LEFT   = 32;
  localparam int DEF_BOX_RIGHT  = 607;
  localparam int DEF_BOX_TOP    = 32;
  localparam int DEF_BOX_BOTTOM = 447;

  localparam logic WALL_BIT = 1'b1;

  typedef struct packed {
    logic [POS_W-1:0] pos;
    logic             neg;
  } axis_t;

  // Signed compares keep pos - speed from wrapping below zero near the low wall.
  function automatic axis_t step_axis(input logic [POS_W-1:0]   pos,
                                      input logic               neg,
                                      input logic [SPEED_W-1:0] spd,
                                      input logic signed [POS_W:0] lo,
                                      input logic signed [POS_W:0] hi);
    axis_t r;
    logic signed [POS_W:0] p;
    logic signed [POS_W:0] s;
    p = signed'({1'b0, pos});
    s = signed'({{(POS_W + 1 - SPEED_W){1'b0}}, spd});
    r.pos = pos;
    r.neg = neg;
    if (!neg) begin
      if (p + s > hi) begin
        r.pos = hi[POS_W-1:0];
        r.neg = 1'b1;
      end else begin
        r.pos = pos + {{(POS_W - SPEED_W){1'b0}}, spd};
      end
    end else begin
      if (p - s < lo) begin
        r.pos = lo[POS_W-1:0];
        r.neg = 1'b0;
      end else begin
        r.pos = pos - {{(POS_W - SPEED_W){1'b0}}, spd};
      end
    end
    return r;
  endfunction

  // Colour 0 would vanish into the background, so it is remapped to 1.
  function automatic int ball_colour(input int idx, input int rgb_w);
    int m;
    int c;
    m = (1 << rgb_w) - 1;
    c = (idx + 1) % m;
    return (c == 0) ? 1 : c;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// 640x480 raster counters with raw (unregistered) syncs, visible-area flag and
// the end-of-visible-frame pulse that drives ball motion.
module vga_timing
  import vga_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  output logic [H_W-1:0] h,
  output logic [V_W-1:0] v,
  output logic           hsync_raw,
  output logic           vsync_raw,
  output logic           video_on,
  output logic           frame_tick
);

  logic [H_W-1:0] h_q, h_d;
  logic [V_W-1:0] v_q, v_d;

  always_comb begin
    h_d = h_q + H_W'(1);
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + V_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h          = h_q;
  assign v          = v_q;
  assign hsync_raw  = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
  assign vsync_raw  = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
  assign video_on   = (h_q < H_VIS_END) && (v_q < V_VIS_END);
  assign frame_tick = (h_q == H_LAST) && (v_q == V_VIS_LAST);

endmodule

// File: rtl/multi_ball_box_top.sv
// Bouncing-ball demo: NUM_BALLS squares inside a walled box, with pause and
// speed buttons, driving registered VGA sync and colour pins.
module multi_ball_box_top
  import vga_pkg::*;
#(
  parameter int NUM_BALLS  = 2,
  parameter int RGB_W      = 3,
  parameter int BALL_SIZE  = 8,
  parameter int BOX_LEFT   = DEF_BOX_LEFT,
  parameter int BOX_RIGHT  = DEF_BOX_RIGHT,
  parameter int BOX_TOP    = DEF_BOX_TOP,
  parameter int BOX_BOTTOM = DEF_BOX_BOTTOM
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       btn,
  output logic             vga_hsync,
  output logic             vga_vsync,
  output logic [RGB_W-1:0] vga_rgb
);

  localparam logic signed [POS_W:0] X_LO = (POS_W + 1)'(BOX_LEFT + 1);
  localparam logic signed [POS_W:0] X_HI = (POS_W + 1)'(BOX_RIGHT - BALL_SIZE);
  localparam logic signed [POS_W:0] Y_LO = (POS_W + 1)'(BOX_TOP + 1);
  localparam logic signed [POS_W:0] Y_HI = (POS_W + 1)'(BOX_BOTTOM - BALL_SIZE);

  localparam logic [H_W-1:0] WALL_L = H_W'(BOX_LEFT);
  localparam logic [H_W-1:0] WALL_R = H_W'(BOX_RIGHT);
  localparam logic [V_W-1:0] WALL_T = V_W'(BOX_TOP);
  localparam logic [V_W-1:0] WALL_B = V_W'(BOX_BOTTOM);
  localparam logic [POS_W:0] BALL_SPAN = (POS_W + 1)'(BALL_SIZE - 1);

  logic [H_W-1:0] h;
  logic [V_W-1:0] v;
  logic           hsync_raw;
  logic           vsync_raw;
  logic           video_on;
  logic           frame_tick;

  vga_timing u_timing (
    .clk        (clk),
    .reset      (reset),
    .h          (h),
    .v          (v),
    .hsync_raw  (hsync_raw),
    .vsync_raw  (vsync_raw),
    .video_on   (video_on),
    .frame_tick (frame_tick)
  );

  logic [1:0]         btn_meta_q, btn_meta_d;
  logic [1:0]         btn_sync_q, btn_sync_d;
  logic [1:0]         btn_prev_q, btn_prev_d;
  logic [1:0]         btn_rise;
  logic               paused_q, paused_d;
  logic [SPEED_W-1:0] speed_q, speed_d;

  // Two-flop synchroniser, then a rising-edge detector on the synchronised copy.
  always_comb begin
    btn_meta_d = btn;
    btn_sync_d = btn_meta_q;
    btn_prev_d = btn_sync_q;
    btn_rise   = btn_sync_q & ~btn_prev_q;
    paused_d   = paused_q ^ btn_rise[0];
    speed_d    = speed_q;
    if (btn_rise[1]) begin
      speed_d = (speed_q == SPEED_W'(4)) ? SPEED_W'(1) : speed_q + SPEED_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      btn_prev_q <= '0;
      paused_q   <= 1'b0;
      speed_q    <= SPEED_W'(1);
    end else begin
      btn_meta_q <= btn_meta_d;
      btn_sync_q <= btn_sync_d;
      btn_prev_q <= btn_prev_d;
      paused_q   <= paused_d;
      speed_q    <= speed_d;
    end
  end

  logic [NUM_BALLS-1:0] ball_hit;

  for (genvar i = 0; i < NUM_BALLS; i++) begin : g_ball
    localparam logic [POS_W-1:0] X_INIT  = POS_W'(BOX_LEFT + 1 + 64 * i);
    localparam logic [POS_W-1:0] Y_INIT  = POS_W'(BOX_TOP + 1 + 32 * i);
    localparam logic             DX_INIT = ((i % 2) == 1);

    logic [POS_W-1:0] x_q, x_d;
    logic [POS_W-1:0] y_q, y_d;
    logic             dx_neg_q, dx_neg_d;
    logic             dy_neg_q, dy_neg_d;
    axis_t            x_step;
    axis_t            y_step;

    always_comb begin
      x_step   = step_axis(x_q, dx_neg_q, speed_q, X_LO, X_HI);
      y_step   = step_axis(y_q, dy_neg_q, speed_q, Y_LO, Y_HI);
      x_d      = x_q;
      y_d      = y_q;
      dx_neg_d = dx_neg_q;
      dy_neg_d = dy_neg_q;
      if (frame_tick && !paused_q) begin
        x_d      = x_step.pos;
        dx_neg_d = x_step.neg;
        y_d      = y_step.pos;
        dy_neg_d = y_step.neg;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        x_q      <= X_INIT;
        y_q      <= Y_INIT;
        dx_neg_q <= DX_INIT;
        dy_neg_q <= 1'b0;
      end else begin
        x_q      <= x_d;
        y_q      <= y_d;
        dx_neg_q <= dx_neg_d;
        dy_neg_q <= dy_neg_d;
      end
    end

    assign ball_hit[i] = ({1'b0, h} >= {1'b0, x_q}) &&
                         ({1'b0, h} <= {1'b0, x_q} + BALL_SPAN) &&
                         ({1'b0, v} >= {1'b0, y_q}) &&
                         ({1'b0, v} <= {1'b0, y_q} + BALL_SPAN);
  end

  logic             wall;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;

  assign wall = (((h == WALL_L) || (h == WALL_R)) && (v >= WALL_T) && (v <= WALL_B)) ||
                (((v == WALL_T) || (v == WALL_B)) && (h >= WALL_L) && (h <= WALL_R));

  // Descending scan so the lowest-index ball is the last to write and wins.
  always_comb begin
    hsync_d = hsync_raw;
    vsync_d = vsync_raw;
    rgb_d   = '0;
    if (video_on) begin
      if (wall) begin
        rgb_d = {RGB_W{WALL_BIT}};
      end else begin
        for (int i = NUM_BALLS - 1; i >= 0; i--) begin
          if (ball_hit[i]) begin
            rgb_d = RGB_W'(ball_colour(i, RGB_W));
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= '0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
    end
  end

  assign vga_hsync = hsync_q;
  assign vga_vsync = vsync_q;
  assign vga_rgb   = rgb_q;

endmodule

// File: tb/tb_multi_ball_box_top.sv
// Directed bench for the bouncing-ball top: raster timing, motion, bounce,
// pause/speed buttons and pixel priority, with raster jumps to skip idle lines.
module tb_multi_ball_box_top;

  logic       clk;
  logic       reset;
  logic [1:0] btn;
  logic [1:0] btn_b;
  logic       hsync, vsync, hsync_b, vsync_b;
  logic [2:0] rgb, rgb_b;
  logic [9:0] jump_h, jump_v;
  int         checks = 0;
  int         errors = 0;

  multi_ball_box_top dut (
    .clk       (clk),
    .reset     (reset),
    .btn       (btn),
    .vga_hsync (hsync),
    .vga_vsync (vsync),
    .vga_rgb   (rgb)
  );

  multi_ball_box_top #(.BOX_RIGHT(50)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .btn       (btn_b),
    .vga_hsync (hsync_b),
    .vga_vsync (vsync_b),
    .vga_rgb   (rgb_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One-cycle pulse on both button buses; the effect is visible two ticks later.
  task automatic applyStimulus(input logic [1:0] a, input logic [1:0] b);
    btn   = a;
    btn_b = b;
    tick(1);
    btn   = 2'b00;
    btn_b = 2'b00;
  endtask

  task automatic jumpTo(input logic [9:0] hv, input logic [9:0] vv);
    jump_h = hv;
    jump_v = vv;
    force dut.u_timing.h_q = jump_h;
    force dut.u_timing.v_q = jump_v;
    #1;
    release dut.u_timing.h_q;
    release dut.u_timing.v_q;
  endtask

  task automatic pixelCheck(input string tag, input logic [9:0] hv,
                            input logic [9:0] vv, input logic [31:0] expected);
    jumpTo(hv, vv);
    tick(1);
    checkOutput(tag, 32'(rgb), expected);
  endtask

  task automatic frameTick();
    jump_h = 10'd798;
    jump_v = 10'd479;
    force dut.u_timing.h_q   = jump_h;
    force dut.u_timing.v_q   = jump_v;
    force dut_b.u_timing.h_q = jump_h;
    force dut_b.u_timing.v_q = jump_v;
    #1;
    release dut.u_timing.h_q;
    release dut.u_timing.v_q;
    release dut_b.u_timing.h_q;
    release dut_b.u_timing.v_q;
    tick(1);
    checkOutput("frame_tick", 32'(dut.frame_tick), 1);
    tick(1);
  endtask

  initial begin
    reset  = 1'b1;
    btn    = 2'b00;
    btn_b  = 2'b00;
    jump_h = '0;
    jump_v = '0;
    tick(5);
    $display("[TB] reset state");
    checkOutput("rst_hsync", 32'(hsync), 1);
    checkOutput("rst_vsync", 32'(vsync), 1);
    checkOutput("rst_rgb", 32'(rgb), 0);
    checkOutput("rst_paused", 32'(dut.paused_q), 0);
    checkOutput("rst_speed", 32'(dut.speed_q), 1);
    checkOutput("rst_x0", 32'(dut.g_ball[0].x_q), 33);
    checkOutput("rst_y0", 32'(dut.g_ball[0].y_q), 33);
    checkOutput("rst_x1", 32'(dut.g_ball[1].x_q), 97);
    checkOutput("rst_y1", 32'(dut.g_ball[1].y_q), 65);
    checkOutput("rst_dxneg1", 32'(dut.g_ball[1].dx_neg_q), 1);
    checkOutput("rst_dxneg0", 32'(dut.g_ball[0].dx_neg_q), 0);
    reset = 1'b0;

    $display("[TB] hsync timing");
    tick(656);
    checkOutput("hs_656", 32'(hsync), 1);
    tick(1);
    checkOutput("hs_657", 32'(hsync), 0);
    tick(95);
    checkOutput("hs_752", 32'(hsync), 0);
    tick(1);
    checkOutput("hs_753", 32'(hsync), 1);
    tick(703);
    checkOutput("hs_1456", 32'(hsync), 1);
    tick(1);
    checkOutput("hs_1457", 32'(hsync), 0);

    $display("[TB] vsync timing");
    jumpTo(10'd798, 10'd489);
    tick(2);
    checkOutput("vs_489", 32'(vsync), 1);
    tick(1);
    checkOutput("vs_start", 32'(vsync), 0);
    tick(1599);
    checkOutput("vs_last", 32'(vsync), 0);
    tick(1);
    checkOutput("vs_end", 32'(vsync), 1);

    $display("[TB] speed 4 on narrow box");
    applyStimulus(2'b00, 2'b10);
    tick(2);
    checkOutput("b_speed2", 32'(dut_b.speed_q), 2);
    applyStimulus(2'b00, 2'b10);
    tick(2);
    checkOutput("b_speed3", 32'(dut_b.speed_q), 3);
    applyStimulus(2'b00, 2'b10);
    tick(2);
    checkOutput("b_speed4", 32'(dut_b.speed_q), 4);

    $display("[TB] first frame of motion");
    frameTick();
    checkOutput("m1_x0", 32'(dut.g_ball[0].x_q), 34);
    checkOutput("m1_y0", 32'(dut.g_ball[0].y_q), 34);
    checkOutput("m1_x1", 32'(dut.g_ball[1].x_q), 96);
    checkOutput("m1_y1", 32'(dut.g_ball[1].y_q), 66);
    checkOutput("b1_x0", 32'(dut_b.g_ball[0].x_q), 37);

    $display("[TB] pixel rendering");
    pixelCheck("px_33_34", 10'd33, 10'd34, 0);
    pixelCheck("px_34_34", 10'd34, 10'd34, 1);
    pixelCheck("px_41_41", 10'd41, 10'd41, 1);
    pixelCheck("px_42_34", 10'd42, 10'd34, 0);
    pixelCheck("px_96_66", 10'd96, 10'd66, 2);
    pixelCheck("px_103_73", 10'd103, 10'd73, 2);
    pixelCheck("px_104_73", 10'd104, 10'd73, 0);
    pixelCheck("wall_32_100", 10'd32, 10'd100, 7);
    pixelCheck("wall_607_447", 10'd607, 10'd447, 7);
    pixelCheck("wall_40_32", 10'd40, 10'd32, 7);
    pixelCheck("blank_700_10", 10'd700, 10'd10, 0);
    checkOutput("blank_hsync", 32'(hsync), 0);

    $display("[TB] pause");
    applyStimulus(2'b01, 2'b00);
    tick(1);
    checkOutput("pause_c2", 32'(dut.paused_q), 0);
    tick(1);
    checkOutput("pause_c3", 32'(dut.paused_q), 1);
    frameTick();
    checkOutput("p1_x0", 32'(dut.g_ball[0].x_q), 34);
    checkOutput("b2_x0", 32'(dut_b.g_ball[0].x_q), 41);
    frameTick();
    checkOutput("p2_x0", 32'(dut.g_ball[0].x_q), 34);
    checkOutput("p2_x1", 32'(dut.g_ball[1].x_q), 96);
    checkOutput("b3_x0", 32'(dut_b.g_ball[0].x_q), 42);
    checkOutput("b3_dxneg", 32'(dut_b.g_ball[0].dx_neg_q), 1);
    frameTick();
    checkOutput("p3_y0", 32'(dut.g_ball[0].y_q), 34);
    checkOutput("b4_x0", 32'(dut_b.g_ball[0].x_q), 38);

    $display("[TB] resume");
    applyStimulus(2'b01, 2'b00);
    tick(2);
    checkOutput("resume", 32'(dut.paused_q), 0);
    frameTick();
    checkOutput("r_x0", 32'(dut.g_ball[0].x_q), 35);
    checkOutput("r_y0", 32'(dut.g_ball[0].y_q), 35);
    checkOutput("r_x1", 32'(dut.g_ball[1].x_q), 95);
    checkOutput("b5_x0", 32'(dut_b.g_ball[0].x_q), 34);

    $display("[TB] speed cycling");
    applyStimulus(2'b10, 2'b00);
    tick(2);
    checkOutput("speed_a", 32'(dut.speed_q), 2);
    applyStimulus(2'b10, 2'b00);
    tick(2);
    checkOutput("speed_b", 32'(dut.speed_q), 3);
    applyStimulus(2'b10, 2'b00);
    tick(2);
    checkOutput("speed_c", 32'(dut.speed_q), 4);
    applyStimulus(2'b10, 2'b00);
    tick(2);
    checkOutput("speed_d", 32'(dut.speed_q), 1);
    applyStimulus(2'b11, 2'b00);
    tick(2);
    checkOutput("both_paused", 32'(dut.paused_q), 1);
    checkOutput("both_speed", 32'(dut.speed_q), 2);
    applyStimulus(2'b01, 2'b00);
    tick(2);
    checkOutput("unpause", 32'(dut.paused_q), 0);
    frameTick();
    checkOutput("s_x0", 32'(dut.g_ball[0].x_q), 37);
    checkOutput("s_y0", 32'(dut.g_ball[0].y_q), 37);
    checkOutput("s_x1", 32'(dut.g_ball[1].x_q), 93);
    checkOutput("s_y1", 32'(dut.g_ball[1].y_q), 69);
    checkOutput("b6_x0", 32'(dut_b.g_ball[0].x_q), 33);
    checkOutput("b6_dxneg", 32'(dut_b.g_ball[0].dx_neg_q), 0);

    $display("[TB] overlap priority");
    force dut.g_ball[1].x_q = 10'd40;
    force dut.g_ball[1].y_q = 10'd40;
    #1;
    release dut.g_ball[1].x_q;
    release dut.g_ball[1].y_q;
    pixelCheck("ov_42_42", 10'd42, 10'd42, 1);
    pixelCheck("ov_46_42", 10'd46, 10'd42, 2);
    pixelCheck("ov_36_42", 10'd36, 10'd42, 0);

    $display("[TB] mid-frame reset");
    jumpTo(10'd42, 10'd42);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checkOutput("mr_rgb", 32'(rgb), 0);
    checkOutput("mr_h", 32'(dut.u_timing.h_q), 0);
    checkOutput("mr_x0", 32'(dut.g_ball[0].x_q), 33);
    checkOutput("mr_x1", 32'(dut.g_ball[1].x_q), 97);
    checkOutput("mr_speed", 32'(dut.speed_q), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
